// File: rtl/rice_core_pkg.sv
// rtl/rice_core_pkg.sv - rice core memory access, lsu error and lsu command types
package rice_core_pkg;

  typedef enum logic [1:0] {
    RICE_CORE_MEMORY_ACCESS_TYPE_NONE  = 2'b00,
    RICE_CORE_MEMORY_ACCESS_TYPE_STORE = 2'b01,
    RICE_CORE_MEMORY_ACCESS_TYPE_LOAD  = 2'b10
  } rice_core_memory_access_type;

  typedef enum logic [2:0] {
    RICE_CORE_MEMORY_ACCESS_MODE_B  = 3'b000,
    RICE_CORE_MEMORY_ACCESS_MODE_H  = 3'b001,
    RICE_CORE_MEMORY_ACCESS_MODE_W  = 3'b010,
    RICE_CORE_MEMORY_ACCESS_MODE_D  = 3'b011,
    RICE_CORE_MEMORY_ACCESS_MODE_BU = 3'b100,
    RICE_CORE_MEMORY_ACCESS_MODE_HU = 3'b101,
    RICE_CORE_MEMORY_ACCESS_MODE_WU = 3'b110
  } rice_core_memory_access_mode;

  typedef enum logic [1:0] {
    RICE_CORE_LSU_ERROR_NONE         = 2'b00,
    RICE_CORE_LSU_ERROR_MISALIGNED   = 2'b01,
    RICE_CORE_LSU_ERROR_BUS_ERROR    = 2'b10,
    RICE_CORE_LSU_ERROR_ILLEGAL_MODE = 2'b11
  } rice_core_lsu_error;

  localparam int RICE_CORE_LSU_MAX_XLEN          = 64;
  localparam int RICE_CORE_LSU_MAX_ADDRESS_WIDTH = 64;

  typedef struct packed {
    rice_core_memory_access_type access_type;
    rice_core_memory_access_mode access_mode;
  } rice_core_memory_access;

  // Widest supported fields; narrower configurations zero-extend into them.
  typedef struct packed {
    rice_core_memory_access                       access;
    logic [RICE_CORE_LSU_MAX_ADDRESS_WIDTH-1:0]   address;
    logic [RICE_CORE_LSU_MAX_XLEN-1:0]            store_data;
    logic [4:0]                                   rd;
  } rice_core_lsu_command;

  function automatic logic [3:0] rice_core_access_bytes(input logic [2:0] mode);
    case (mode)
      RICE_CORE_MEMORY_ACCESS_MODE_H, RICE_CORE_MEMORY_ACCESS_MODE_HU: return 4'd2;
      RICE_CORE_MEMORY_ACCESS_MODE_W, RICE_CORE_MEMORY_ACCESS_MODE_WU: return 4'd4;
      RICE_CORE_MEMORY_ACCESS_MODE_D:                                  return 4'd8;
      default:                                                         return 4'd1;
    endcase
  endfunction

endpackage

// File: rtl/rice_core_lsu_data_aligner.sv
// rtl/rice_core_lsu_data_aligner.sv - strobe, store lane replication, load extraction and mode checks
module rice_core_lsu_data_aligner
  import rice_core_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]        access_mode,
  input  logic [2:0]        address_low,
  input  logic [XLEN-1:0]   store_data,
  input  logic [XLEN-1:0]   read_data,
  output logic [XLEN/8-1:0] strobe,
  output logic [XLEN-1:0]   write_data,
  output logic [XLEN-1:0]   load_data,
  output logic              misaligned,
  output logic              illegal_mode
);

  localparam int NB = XLEN / 8;
  localparam int LW = $clog2(NB);

  rice_core_memory_access_mode mode;
  logic [LW-1:0]   lane;
  logic [3:0]      size_bytes;
  logic [NB-1:0]   base;
  logic [XLEN-1:0] shifted;
  logic [XLEN-1:0] left;
  logic [6:0]      pad;
  logic            sign_extend;

  always_comb begin
    mode       = rice_core_memory_access_mode'(access_mode);
    lane       = address_low[LW-1:0];
    size_bytes = rice_core_access_bytes(access_mode);

    case (mode)
      RICE_CORE_MEMORY_ACCESS_MODE_D,
      RICE_CORE_MEMORY_ACCESS_MODE_WU: illegal_mode = (XLEN == 32);
      RICE_CORE_MEMORY_ACCESS_MODE_B,
      RICE_CORE_MEMORY_ACCESS_MODE_H,
      RICE_CORE_MEMORY_ACCESS_MODE_W,
      RICE_CORE_MEMORY_ACCESS_MODE_BU,
      RICE_CORE_MEMORY_ACCESS_MODE_HU: illegal_mode = 1'b0;
      default:                         illegal_mode = 1'b1;
    endcase

    // size is a power of two, so size-1 masks the offset within the access
    misaligned = (address_low & (size_bytes[2:0] - 3'd1)) != 3'd0;

    for (int i = 0; i < NB; i++) begin
      base[i] = (4'(i) < size_bytes);
    end
    strobe = base << lane;

    case (mode)
      RICE_CORE_MEMORY_ACCESS_MODE_B,
      RICE_CORE_MEMORY_ACCESS_MODE_BU: write_data = {NB{store_data[7:0]}};
      RICE_CORE_MEMORY_ACCESS_MODE_H,
      RICE_CORE_MEMORY_ACCESS_MODE_HU: write_data = {(NB/2){store_data[15:0]}};
      RICE_CORE_MEMORY_ACCESS_MODE_W,
      RICE_CORE_MEMORY_ACCESS_MODE_WU: write_data = {(NB/4){store_data[31:0]}};
      default:                         write_data = store_data;
    endcase

    // Extract by pushing the field to the top, then shifting back down
    // arithmetically or logically.
    shifted     = read_data >> {lane, 3'b000};
    pad         = 7'(XLEN) - {size_bytes, 3'b000};
    left        = shifted << pad;
    sign_extend = (mode == RICE_CORE_MEMORY_ACCESS_MODE_B) ||
                  (mode == RICE_CORE_MEMORY_ACCESS_MODE_H) ||
                  (mode == RICE_CORE_MEMORY_ACCESS_MODE_W);
    if (illegal_mode) begin
      load_data = '0;
    end else if (mode == RICE_CORE_MEMORY_ACCESS_MODE_D) begin
      load_data = read_data;
    end else if (sign_extend) begin
      load_data = $signed(left) >>> pad;
    end else begin
      load_data = left >> pad;
    end
  end

endmodule

// File: rtl/rice_core_lsu.sv
// rtl/rice_core_lsu.sv - rice core load/store unit: command capture, bus request, response, result
module rice_core_lsu
  import rice_core_pkg::*;
#(
  parameter int XLEN          = 32,
  parameter int ADDRESS_WIDTH = 32
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_valid,
  output logic                     o_ready,
  input  logic [1:0]               i_access_type,
  input  logic [2:0]               i_access_mode,
  input  logic [ADDRESS_WIDTH-1:0] i_address,
  input  logic [XLEN-1:0]          i_store_data,
  input  logic [4:0]               i_rd,
  output logic                     o_bus_request_valid,
  input  logic                     i_bus_request_ready,
  output logic                     o_bus_write,
  output logic [ADDRESS_WIDTH-1:0] o_bus_address,
  output logic [XLEN/8-1:0]        o_bus_strobe,
  output logic [XLEN-1:0]          o_bus_write_data,
  input  logic                     i_bus_response_valid,
  input  logic [XLEN-1:0]          i_bus_response_data,
  input  logic                     i_bus_response_error,
  output logic                     o_result_valid,
  input  logic                     i_result_ready,
  output logic [XLEN-1:0]          o_result_data,
  output logic [4:0]               o_result_rd,
  output logic [1:0]               o_result_error
);

  localparam int LW = $clog2(XLEN / 8);

  typedef enum logic [1:0] {IDLE, REQUEST, WAIT_RESPONSE, RESULT} state_t;

  state_t               state;
  rice_core_lsu_command cmd_q;

  logic [2:0]        al_mode;
  logic [2:0]        al_address_low;
  logic [XLEN/8-1:0] al_strobe;
  logic [XLEN-1:0]   al_write_data;
  logic [XLEN-1:0]   al_load_data;
  logic              al_misaligned;
  logic              al_illegal_mode;
  logic              is_store;
  logic              is_load;
  logic              unused_cmd_bits;

  // The aligner checks the incoming command in IDLE and extracts load data
  // from the captured command afterwards.
  assign al_mode        = (state == IDLE) ? i_access_mode  : cmd_q.access.access_mode;
  assign al_address_low = (state == IDLE) ? i_address[2:0] : cmd_q.address[2:0];

  rice_core_lsu_data_aligner #(.XLEN(XLEN)) u_aligner (
    .access_mode  (al_mode),
    .address_low  (al_address_low),
    .store_data   (i_store_data),
    .read_data    (i_bus_response_data),
    .strobe       (al_strobe),
    .write_data   (al_write_data),
    .load_data    (al_load_data),
    .misaligned   (al_misaligned),
    .illegal_mode (al_illegal_mode)
  );

  assign is_store = (i_access_type == RICE_CORE_MEMORY_ACCESS_TYPE_STORE);
  assign is_load  = (i_access_type == RICE_CORE_MEMORY_ACCESS_TYPE_LOAD);

  assign o_ready             = (state == IDLE);
  assign o_bus_request_valid = (state == REQUEST);
  assign o_result_valid      = (state == RESULT);

  assign unused_cmd_bits = ^{cmd_q.address, cmd_q.store_data, cmd_q.rd};

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state            <= IDLE;
      cmd_q            <= '0;
      o_bus_write      <= 1'b0;
      o_bus_address    <= '0;
      o_bus_strobe     <= '0;
      o_bus_write_data <= '0;
      o_result_data    <= '0;
      o_result_rd      <= '0;
      o_result_error   <= RICE_CORE_LSU_ERROR_NONE;
    end else begin
      case (state)
        IDLE: begin
          if (i_valid) begin
            cmd_q.access.access_type <= rice_core_memory_access_type'(i_access_type);
            cmd_q.access.access_mode <= rice_core_memory_access_mode'(i_access_mode);
            cmd_q.address            <= RICE_CORE_LSU_MAX_ADDRESS_WIDTH'(i_address);
            cmd_q.store_data         <= RICE_CORE_LSU_MAX_XLEN'(i_store_data);
            cmd_q.rd                 <= i_rd;
            o_result_rd              <= i_rd;
            o_result_data            <= '0;
            o_result_error           <= RICE_CORE_LSU_ERROR_NONE;
            if (al_illegal_mode) begin
              o_result_error <= RICE_CORE_LSU_ERROR_ILLEGAL_MODE;
              state          <= RESULT;
            end else if (al_misaligned) begin
              o_result_error <= RICE_CORE_LSU_ERROR_MISALIGNED;
              state          <= RESULT;
            end else if (is_store || is_load) begin
              o_bus_write      <= is_store;
              o_bus_address    <= {i_address[ADDRESS_WIDTH-1:LW], {LW{1'b0}}};
              o_bus_strobe     <= is_store ? al_strobe : '1;
              o_bus_write_data <= al_write_data;
              state            <= REQUEST;
            end else begin
              state <= RESULT;
            end
          end
        end
        REQUEST: begin
          if (i_bus_request_ready) state <= WAIT_RESPONSE;
        end
        WAIT_RESPONSE: begin
          if (i_bus_response_valid) begin
            state <= RESULT;
            if (i_bus_response_error) begin
              o_result_error <= RICE_CORE_LSU_ERROR_BUS_ERROR;
              o_result_data  <= '0;
            end else if (cmd_q.access.access_type == RICE_CORE_MEMORY_ACCESS_TYPE_LOAD) begin
              o_result_data <= al_load_data;
            end else begin
              o_result_data <= '0;
            end
          end
        end
        RESULT: begin
          if (i_result_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rice_core_lsu.sv
// tb/tb_rice_core_lsu.sv - directed scoreboard bench for rice_core_lsu at XLEN 32 and 64
module tb_rice_core_lsu;
  import rice_core_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  valid;
  logic [1:0]  access_type;
  logic [2:0]  access_mode;
  logic [31:0] address;
  logic [63:0] store_data;
  logic [4:0]  rd;
  logic        req_ready, resp_valid, resp_error, res_ready;
  logic [63:0] resp_data;

  logic        r32_ready, r32_req_valid, r32_write, r32_res_valid;
  logic [31:0] r32_addr, r32_wdata, r32_res_data;
  logic [3:0]  r32_strobe;
  logic [4:0]  r32_rd;
  logic [1:0]  r32_err;

  logic        r64_ready, r64_req_valid, r64_write, r64_res_valid;
  logic [31:0] r64_addr;
  logic [63:0] r64_wdata, r64_res_data;
  logic [7:0]  r64_strobe;
  logic [4:0]  r64_rd;
  logic [1:0]  r64_err;

  typedef struct {
    logic [63:0] data;
    logic [4:0]  rd;
    logic [1:0]  err;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_miss = 0;
  int   cyc = 0;
  int   acc_cyc = 0;
  bit   sel = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  rice_core_lsu #(.XLEN(32), .ADDRESS_WIDTH(32)) dut32 (
    .i_clk(clk), .i_rst(rst), .i_valid(valid[0]), .o_ready(r32_ready),
    .i_access_type(access_type), .i_access_mode(access_mode), .i_address(address),
    .i_store_data(store_data[31:0]), .i_rd(rd),
    .o_bus_request_valid(r32_req_valid), .i_bus_request_ready(req_ready),
    .o_bus_write(r32_write), .o_bus_address(r32_addr), .o_bus_strobe(r32_strobe),
    .o_bus_write_data(r32_wdata), .i_bus_response_valid(resp_valid),
    .i_bus_response_data(resp_data[31:0]), .i_bus_response_error(resp_error),
    .o_result_valid(r32_res_valid), .i_result_ready(res_ready),
    .o_result_data(r32_res_data), .o_result_rd(r32_rd), .o_result_error(r32_err)
  );

  rice_core_lsu #(.XLEN(64), .ADDRESS_WIDTH(32)) dut64 (
    .i_clk(clk), .i_rst(rst), .i_valid(valid[1]), .o_ready(r64_ready),
    .i_access_type(access_type), .i_access_mode(access_mode), .i_address(address),
    .i_store_data(store_data), .i_rd(rd),
    .o_bus_request_valid(r64_req_valid), .i_bus_request_ready(req_ready),
    .o_bus_write(r64_write), .o_bus_address(r64_addr), .o_bus_strobe(r64_strobe),
    .o_bus_write_data(r64_wdata), .i_bus_response_valid(resp_valid),
    .i_bus_response_data(resp_data), .i_bus_response_error(resp_error),
    .o_result_valid(r64_res_valid), .i_result_ready(res_ready),
    .o_result_data(r64_res_data), .o_result_rd(r64_rd), .o_result_error(r64_err)
  );

  function automatic logic ob_ready();        return sel ? r64_ready     : r32_ready;     endfunction
  function automatic logic ob_req_valid();    return sel ? r64_req_valid : r32_req_valid; endfunction
  function automatic logic ob_res_valid();    return sel ? r64_res_valid : r32_res_valid; endfunction
  function automatic logic ob_write();        return sel ? r64_write     : r32_write;     endfunction
  function automatic logic [31:0] ob_addr();  return sel ? r64_addr      : r32_addr;      endfunction
  function automatic logic [7:0] ob_strobe(); return sel ? r64_strobe    : {4'd0, r32_strobe}; endfunction
  function automatic logic [63:0] ob_wdata(); return sel ? r64_wdata     : {32'd0, r32_wdata}; endfunction
  function automatic logic [63:0] ob_rdata(); return sel ? r64_res_data  : {32'd0, r32_res_data}; endfunction
  function automatic logic [4:0] ob_rd();     return sel ? r64_rd        : r32_rd;        endfunction
  function automatic logic [1:0] ob_err();    return sel ? r64_err       : r32_err;       endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input bit s, input logic [1:0] t, input logic [2:0] m, input logic [31:0] a,
                       input logic [63:0] d, input logic [4:0] r, input logic [63:0] e_data,
                       input logic [1:0] e_err);
    exp_t e;
    sel = s;
    chk("ready_before_issue", 64'(ob_ready()), 64'd1);
    access_type = t;
    access_mode = m;
    address     = a;
    store_data  = d;
    rd          = r;
    valid[s]    = 1'b1;
    acc_cyc     = cyc;
    e.data = e_data;
    e.rd   = r;
    e.err  = e_err;
    sb.push_back(e);
    @(negedge clk);
    valid = 2'b00;
  endtask

  task automatic bus_txn(input int stall, input logic [63:0] rdata, input logic err,
                         input logic [31:0] e_addr, input logic [7:0] e_strobe,
                         input logic [63:0] e_wdata, input logic e_write);
    int n = 0;
    while (!ob_req_valid() && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("req_valid", 64'(ob_req_valid()), 64'd1);
    for (int i = 0; i <= stall; i++) begin
      chk("bus_addr", 64'(ob_addr()), 64'(e_addr));
      chk("bus_strobe", 64'(ob_strobe()), 64'(e_strobe));
      chk("bus_wdata", ob_wdata(), e_wdata);
      chk("bus_write", 64'(ob_write()), 64'(e_write));
      if (i < stall) @(negedge clk);
    end
    req_ready = 1'b1;
    @(negedge clk);
    req_ready = 1'b0;
    chk("req_dropped", 64'(ob_req_valid()), 64'd0);
    resp_valid = 1'b1;
    resp_data  = rdata;
    resp_error = err;
    @(negedge clk);
    resp_valid = 1'b0;
    resp_error = 1'b0;
  endtask

  task automatic take_result(input int hold, input int e_lat);
    exp_t e;
    int n = 0;
    while (!ob_res_valid() && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("result_valid", 64'(ob_res_valid()), 64'd1);
    if (e_lat >= 0) chk("latency", 64'(cyc - acc_cyc), 64'(e_lat));
    for (int i = 0; i < hold; i++) begin
      chk("ready_low_in_result", 64'(ob_ready()), 64'd0);
      chk("result_held", 64'(ob_res_valid()), 64'd1);
      @(negedge clk);
    end
    chk("sb_depth", 64'(sb.size()), 64'd1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("result_data", ob_rdata(), e.data);
      chk("result_rd", 64'(ob_rd()), 64'(e.rd));
      chk("result_err", 64'(ob_err()), 64'(e.err));
    end
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    chk("ready_after_result", 64'(ob_ready()), 64'd1);
    chk("result_valid_drop", 64'(ob_res_valid()), 64'd0);
  endtask

  task automatic check_idle_reset_values(input string tag);
    chk({tag, "_ready"}, 64'(ob_ready()), 64'd1);
    chk({tag, "_req_valid"}, 64'(ob_req_valid()), 64'd0);
    chk({tag, "_res_valid"}, 64'(ob_res_valid()), 64'd0);
    chk({tag, "_bus_addr"}, 64'(ob_addr()), 64'd0);
    chk({tag, "_bus_strobe"}, 64'(ob_strobe()), 64'd0);
    chk({tag, "_bus_wdata"}, ob_wdata(), 64'd0);
    chk({tag, "_bus_write"}, 64'(ob_write()), 64'd0);
    chk({tag, "_res_data"}, ob_rdata(), 64'd0);
    chk({tag, "_res_rd"}, 64'(ob_rd()), 64'd0);
    chk({tag, "_res_err"}, 64'(ob_err()), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout n_vec=%0d", n_vec);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; valid = 2'b00; access_type = '0; access_mode = '0; address = '0;
    store_data = '0; rd = '0; req_ready = 1'b0; resp_valid = 1'b0; resp_error = 1'b0;
    resp_data = '0; res_ready = 1'b0;
    repeat (2) @(negedge clk);
    sel = 1'b0; check_idle_reset_values("rst32");
    sel = 1'b1; check_idle_reset_values("rst64");
    rst = 1'b0;
    @(negedge clk);

    // XLEN=32 LOAD B, lane 3, sign extension, zero-wait latency
    issue(0, RICE_CORE_MEMORY_ACCESS_TYPE_LOAD, RICE_CORE_MEMORY_ACCESS_MODE_B, 32'h103, 64'd0, 5'd5,
          64'hFFFF_FF80, RICE_CORE_LSU_ERROR_NONE);
    bus_txn(0, 64'h8000_0000, 1'b0, 32'h100, 8'h0F, 64'd0, 1'b0);
    take_result(0, 3);

    // XLEN=32 STORE H at lane 2
    issue(0, RICE_CORE_MEMORY_ACCESS_TYPE_STORE, RICE_CORE_MEMORY_ACCESS_MODE_H, 32'h202, 64'h1234_ABCD, 5'd6,
          64'd0, RICE_CORE_LSU_ERROR_NONE);
    bus_txn(0, 64'h5555_5555, 1'b0, 32'h200, 8'h0C, 64'hABCD_ABCD, 1'b1);
    take_result(0, 3);

    // XLEN=64 LOAD WU lane 4, LOAD D, STORE B lane 5, LOAD H lane 6
    issue(1, RICE_CORE_MEMORY_ACCESS_TYPE_LOAD, RICE_CORE_MEMORY_ACCESS_MODE_WU, 32'h4, 64'd0, 5'd7,
          64'h0000_0000_8765_4321, RICE_CORE_LSU_ERROR_NONE);
    bus_txn(0, 64'h8765_4321_0000_0000, 1'b0, 32'h0, 8'hFF, 64'd0, 1'b0);
    take_result(0, 3);

    issue(1, RICE_CORE_MEMORY_ACCESS_TYPE_LOAD, RICE_CORE_MEMORY_ACCESS_MODE_D, 32'h8, 64'd0, 5'd8,
          64'hFEDC_BA98_7654_3210, RICE_CORE_LSU_ERROR_NONE);
    bus_txn(0, 64'hFEDC_BA98_7654_3210, 1'b0, 32'h8, 8'hFF, 64'd0, 1'b0);
    take_result(0, 3);

    issue(1, RICE_CORE_MEMORY_ACCESS_TYPE_STORE, RICE_CORE_MEMORY_ACCESS_MODE_B, 32'h15, 64'h0000_0000_0000_775A, 5'd3,
          64'd0, RICE_CORE_LSU_ERROR_NONE);
    bus_txn(0, 64'd0, 1'b0, 32'h10, 8'h20, 64'h5A5A_5A5A_5A5A_5A5A, 1'b1);
    take_result(0, 3);

    issue(1, RICE_CORE_MEMORY_ACCESS_TYPE_LOAD, RICE_CORE_MEMORY_ACCESS_MODE_H, 32'h26, 64'd0, 5'd9,
          64'hFFFF_FFFF_FFFF_8001, RICE_CORE_LSU_ERROR_NONE);
    bus_txn(0, 64'h8001_0000_0000_0000, 1'b0, 32'h20, 8'hFF, 64'd0, 1'b0);
    take_result(0, 3);

    // Early-exit commands: result at cycle 1, no bus request
    issue(0, RICE_CORE_MEMORY_ACCESS_TYPE_LOAD, RICE_CORE_MEMORY_ACCESS_MODE_W, 32'h2, 64'd0, 5'd10,
          64'd0, RICE_CORE_LSU_ERROR_MISALIGNED);
    chk("no_req_misaligned", 64'(ob_req_valid()), 64'd0);
    take_result(0, 1);

    issue(0, RICE_CORE_MEMORY_ACCESS_TYPE_LOAD, RICE_CORE_MEMORY_ACCESS_MODE_D, 32'h2, 64'd0, 5'd11,
          64'd0, RICE_CORE_LSU_ERROR_ILLEGAL_MODE);
    chk("no_req_illegal_d", 64'(ob_req_valid()), 64'd0);
    take_result(0, 1);

    issue(0, RICE_CORE_MEMORY_ACCESS_TYPE_STORE, 3'b111, 32'h0, 64'h1, 5'd12,
          64'd0, RICE_CORE_LSU_ERROR_ILLEGAL_MODE);
    take_result(0, 1);

    issue(1, RICE_CORE_MEMORY_ACCESS_TYPE_LOAD, RICE_CORE_MEMORY_ACCESS_MODE_WU, 32'h6, 64'd0, 5'd13,
          64'd0, RICE_CORE_LSU_ERROR_MISALIGNED);
    take_result(0, 1);

    issue(0, RICE_CORE_MEMORY_ACCESS_TYPE_NONE, RICE_CORE_MEMORY_ACCESS_MODE_B, 32'h3, 64'd0, 5'd14,
          64'd0, RICE_CORE_LSU_ERROR_NONE);
    chk("no_req_none", 64'(ob_req_valid()), 64'd0);
    take_result(0, 1);

    // Bus back-pressure, bus error, held result
    issue(0, RICE_CORE_MEMORY_ACCESS_TYPE_LOAD, RICE_CORE_MEMORY_ACCESS_MODE_HU, 32'h2, 64'd0, 5'd15,
          64'd0, RICE_CORE_LSU_ERROR_BUS_ERROR);
    bus_txn(5, 64'h1234_5678, 1'b1, 32'h0, 8'h0F, 64'd0, 1'b0);
    take_result(3, -1);

    // Reset while waiting for a response
    issue(0, RICE_CORE_MEMORY_ACCESS_TYPE_STORE, RICE_CORE_MEMORY_ACCESS_MODE_W, 32'h300, 64'hCAFE_F00D, 5'd21,
          64'd0, RICE_CORE_LSU_ERROR_NONE);
    chk("req_before_abort", 64'(ob_req_valid()), 64'd1);
    req_ready = 1'b1;
    @(negedge clk);
    req_ready = 1'b0;
    #2 rst = 1'b1;
    #1 check_idle_reset_values("abort");
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    resp_valid = 1'b1;
    resp_data  = 64'hDEAD_BEEF;
    @(negedge clk);
    resp_valid = 1'b0;
    chk("stale_resp_dropped", 64'(ob_res_valid()), 64'd0);
    chk("stale_resp_ready", 64'(ob_ready()), 64'd1);

    issue(0, RICE_CORE_MEMORY_ACCESS_TYPE_LOAD, RICE_CORE_MEMORY_ACCESS_MODE_HU, 32'h306, 64'd0, 5'd22,
          64'h0000_BEEF, RICE_CORE_LSU_ERROR_NONE);
    bus_txn(0, 64'hBEEF_1234, 1'b0, 32'h304, 8'h0F, 64'd0, 1'b0);
    take_result(0, 3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
